// File: rtl/iob_native_ram_pkg.sv
// Shared types and constants for the native-bus RAM responder.
// FSM encoding, bus-error word and counter/strobe widths.
package iob_native_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] BUSERR_WORD = 32'hDEADBEEF;
  localparam int CNT_W = 4;
  localparam int BUS_DATA_W = 32;
  localparam int STRB_W = BUS_DATA_W / 8;

endpackage

// File: rtl/iob_native_byte_ram.sv
// Single-port word array with per-byte write enables.
// Registered read port; dout holds until the next enabled read.
module iob_native_byte_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 10
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  input  logic [DATA_W/8-1:0] we,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   dout
);

  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] dout_d, dout_q;

  always_comb begin
    dout_d = dout_q;
    if (en && we == '0) begin
      dout_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/iob_native_ram_resp.sv
// Native valid/ready RAM responder with configurable wait states.
// Define IOB_NATIVE_RAM_BUSERR_EN to add the err port and range check.
module iob_native_ram_resp
  import iob_native_ram_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready
`ifdef IOB_NATIVE_RAM_BUSERR_EN
  ,
  output logic                err
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DEPTH_LOG2-1:0] in_idx, acc_idx;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     acc_wdata, ram_dout;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W/8-1:0]   acc_wstrb;
  logic                  acc_go;
  logic                  ram_en;

  assign in_idx = address[DEPTH_LOG2+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    acc_go  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (valid) begin
          idx_d   = in_idx;
          wdata_d = wdata;
          wstrb_d = wstrb;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          acc_go  = (WAIT_STATES == 0);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          acc_go  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Zero-wait access fires on the capture edge, so use the live bus.
  assign acc_idx   = (state_q == ST_IDLE) ? in_idx : idx_q;
  assign acc_wdata = (state_q == ST_IDLE) ? wdata  : wdata_q;
  assign acc_wstrb = (state_q == ST_IDLE) ? wstrb  : wstrb_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign ready = (state_q == ST_RESP);

`ifdef IOB_NATIVE_RAM_BUSERR_EN
  logic oor_q, oor_d, in_oor, acc_oor;
  logic err_q, err_d;
  logic rd_oor_q, rd_oor_d;
  logic unused_addr;

  assign in_oor  = (address >> (DEPTH_LOG2 + 2)) != '0;
  assign acc_oor = (state_q == ST_IDLE) ? in_oor : oor_q;

  always_comb begin
    oor_d    = oor_q;
    err_d    = 1'b0;
    rd_oor_d = rd_oor_q;
    if (state_q == ST_IDLE && valid) begin
      oor_d = in_oor;
    end
    if (acc_go) begin
      err_d = acc_oor;
      if (acc_wstrb == '0) begin
        rd_oor_d = acc_oor;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      oor_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_oor_q <= 1'b0;
    end else begin
      oor_q    <= oor_d;
      err_q    <= err_d;
      rd_oor_q <= rd_oor_d;
    end
  end

  assign ram_en      = resetn & acc_go & ~acc_oor;
  assign rdata       = rd_oor_q ? BUSERR_WORD : ram_dout;
  assign err         = err_q;
  assign unused_addr = ^address[1:0];
`else
  logic unused_addr;

  assign ram_en      = resetn & acc_go;
  assign rdata       = ram_dout;
  assign unused_addr = ^{address[1:0],
                         address[ADDR_W-1:DEPTH_LOG2+2]};
`endif

  iob_native_byte_ram #(
    .DATA_W(DATA_W),
    .AW    (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .resetn(resetn),
    .en    (ram_en),
    .we    (acc_wstrb),
    .addr  (acc_idx),
    .din   (acc_wdata),
    .dout  (ram_dout)
  );

endmodule
